// File: rtl/pupil_scan_ctrl.sv
// Frame-level pupil search scheduler: walks lines through the line buffer and blob
// scanner, tracks the widest blob and reports its centre once the blob stops growing.
module pupil_scan_ctrl #(
   parameter int unsigned MAX_RESOLUTION = 112,
   parameter int unsigned NUM_LINES      = 112,
   parameter int unsigned COORD_W        = 8,
   parameter int unsigned SCAN_TIMEOUT   = 255
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               frame_start_i,
   output logic               line_req_o,
   output logic [COORD_W-1:0] line_addr_o,
   input  logic               line_ack_i,
   output logic               scan_start_o,
   input  logic               scan_done_i,
   input  logic               blob_found_i,
   input  logic [COORD_W-1:0] blob_begin_i,
   input  logic [COORD_W-1:0] blob_end_i,
   output logic [COORD_W-1:0] pupil_h_o,
   output logic [COORD_W-1:0] pupil_v_o,
   output logic               pupil_valid_o,
   output logic               frame_error_o,
   output logic               busy_o
);

   localparam int unsigned TIMER_W = $clog2(SCAN_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_LINE,
      S_START_SCAN,
      S_WAIT_SCAN,
      S_EVAL,
      S_REPORT
   } state_e;

   state_e               state_q, state_d;
   logic [COORD_W-1:0]   line_q, line_d;
   logic [COORD_W-1:0]   max_len_q, max_len_d;
   logic [COORD_W-1:0]   best_line_q, best_line_d;
   logic [COORD_W-1:0]   best_center_q, best_center_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 tracking_q, tracking_d;
   logic                 found_q, found_d;
   logic [COORD_W-1:0]   begin_q, begin_d;
   logic [COORD_W-1:0]   end_q, end_d;

   logic                 line_req_q, line_req_d;
   logic [COORD_W-1:0]   line_addr_q, line_addr_d;
   logic                 scan_start_q, scan_start_d;
   logic [COORD_W-1:0]   pupil_h_q, pupil_h_d;
   logic [COORD_W-1:0]   pupil_v_q, pupil_v_d;
   logic                 pupil_valid_q, pupil_valid_d;
   logic                 frame_error_q, frame_error_d;
   logic                 busy_q, busy_d;

   logic                 timer_expired_c;
   logic                 blob_valid_c;
   logic [COORD_W-1:0]   width_c;
   logic [COORD_W:0]     sum_c;
   logic [COORD_W-1:0]   center_c;

   // Latched scanner result, evaluated in EVAL; edges beyond the line are treated as garbage
   assign timer_expired_c = (timer_q == TIMER_W'(SCAN_TIMEOUT - 1));
   assign width_c         = end_q - begin_q;
   assign sum_c           = {1'b0, begin_q} + {1'b0, end_q};
   assign center_c        = sum_c[COORD_W:1];
   assign blob_valid_c    = found_q && (end_q > begin_q) &&
                            (end_q < COORD_W'(MAX_RESOLUTION));

   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      max_len_d     = max_len_q;
      best_line_d   = best_line_q;
      best_center_d = best_center_q;
      timer_d       = timer_q;
      tracking_d    = tracking_q;
      found_d       = found_q;
      begin_d       = begin_q;
      end_d         = end_q;
      frame_error_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (frame_start_i) begin
               state_d    = S_REQ_LINE;
               line_d     = '0;
               max_len_d  = '0;
               tracking_d = 1'b0;
               timer_d    = '0;
            end
         end
         S_REQ_LINE: begin
            if (line_ack_i) begin
               state_d = S_START_SCAN;
            end else if (timer_expired_c) begin
               state_d       = S_IDLE;
               frame_error_d = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_START_SCAN: begin
            state_d = S_WAIT_SCAN;
            timer_d = '0;
         end
         S_WAIT_SCAN: begin
            if (scan_done_i) begin
               state_d = S_EVAL;
               found_d = blob_found_i;
               begin_d = blob_begin_i;
               end_d   = blob_end_i;
            end else if (timer_expired_c) begin
               state_d       = S_IDLE;
               frame_error_d = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_EVAL: begin
            if (blob_valid_c && (width_c > max_len_q)) begin
               max_len_d     = width_c;
               best_line_d   = line_q;
               best_center_d = center_c;
               tracking_d    = 1'b1;
            end
            // Equal width while tracking keeps the earliest line and simply moves on
            if (tracking_q && (!blob_valid_c || (width_c < max_len_q))) begin
               state_d = S_REPORT;
            end else if (line_q == COORD_W'(NUM_LINES - 1)) begin
               if (tracking_d) begin
                  state_d = S_REPORT;
               end else begin
                  state_d       = S_IDLE;
                  frame_error_d = 1'b1;
               end
            end else begin
               line_d  = line_q + COORD_W'(1);
               timer_d = '0;
               state_d = S_REQ_LINE;
            end
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered images of the state being entered
      line_req_d    = (state_d == S_REQ_LINE);
      line_addr_d   = line_d;
      scan_start_d  = (state_d == S_START_SCAN);
      busy_d        = (state_d != S_IDLE);
      pupil_valid_d = (state_d == S_REPORT);
      pupil_h_d     = (state_d == S_REPORT) ? best_center_d : pupil_h_q;
      pupil_v_d     = (state_d == S_REPORT) ? best_line_d   : pupil_v_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         line_q        <= '0;
         max_len_q     <= '0;
         best_line_q   <= '0;
         best_center_q <= '0;
         timer_q       <= '0;
         tracking_q    <= 1'b0;
         found_q       <= 1'b0;
         begin_q       <= '0;
         end_q         <= '0;
         line_req_q    <= 1'b0;
         line_addr_q   <= '0;
         scan_start_q  <= 1'b0;
         pupil_h_q     <= '0;
         pupil_v_q     <= '0;
         pupil_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         max_len_q     <= max_len_d;
         best_line_q   <= best_line_d;
         best_center_q <= best_center_d;
         timer_q       <= timer_d;
         tracking_q    <= tracking_d;
         found_q       <= found_d;
         begin_q       <= begin_d;
         end_q         <= end_d;
         line_req_q    <= line_req_d;
         line_addr_q   <= line_addr_d;
         scan_start_q  <= scan_start_d;
         pupil_h_q     <= pupil_h_d;
         pupil_v_q     <= pupil_v_d;
         pupil_valid_q <= pupil_valid_d;
         frame_error_q <= frame_error_d;
         busy_q        <= busy_d;
      end
   end

   assign line_req_o    = line_req_q;
   assign line_addr_o   = line_addr_q;
   assign scan_start_o  = scan_start_q;
   assign pupil_h_o     = pupil_h_q;
   assign pupil_v_o     = pupil_v_q;
   assign pupil_valid_o = pupil_valid_q;
   assign frame_error_o = frame_error_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_pupil_scan_ctrl.sv
// Bench for pupil_scan_ctrl: table of whole-frame scanner responses with expected
// pupil results, plus hand sequences for handshake timing, timeouts and async reset.
module tb_pupil_scan_ctrl;

   localparam int unsigned CW    = 8;
   localparam int unsigned LINES = 112;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic          line_req;
   logic [CW-1:0] line_addr;
   logic          line_ack = 1'b0;
   logic          scan_start;
   logic          scan_done = 1'b0;
   logic          blob_found = 1'b0;
   logic [CW-1:0] blob_begin = '0;
   logic [CW-1:0] blob_end = '0;
   logic [CW-1:0] pupil_h;
   logic [CW-1:0] pupil_v;
   logic          pupil_valid;
   logic          frame_error;
   logic          busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pupil_scan_ctrl dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .frame_start_i (frame_start),
      .line_req_o    (line_req),
      .line_addr_o   (line_addr),
      .line_ack_i    (line_ack),
      .scan_start_o  (scan_start),
      .scan_done_i   (scan_done),
      .blob_found_i  (blob_found),
      .blob_begin_i  (blob_begin),
      .blob_end_i    (blob_end),
      .pupil_h_o     (pupil_h),
      .pupil_v_o     (pupil_v),
      .pupil_valid_o (pupil_valid),
      .frame_error_o (frame_error),
      .busy_o        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One frame: lines before 'first' and after the listed ones report no blob
   typedef struct {
      int            first;
      int            n;
      logic          f[6];
      logic [CW-1:0] b[6];
      logic [CW-1:0] e[6];
      logic          exp_valid;
      logic          exp_err;
      logic [CW-1:0] exp_h;
      logic [CW-1:0] exp_v;
   } frame_vec_t;

   frame_vec_t    vecs[6];
   logic          lf[LINES];
   logic [CW-1:0] lb[LINES];
   logic [CW-1:0] le[LINES];

   task automatic set_line(input int v, input int k, input logic f, input int b, input int e);
      vecs[v].f[k] = f;
      vecs[v].b[k] = CW'(b);
      vecs[v].e[k] = CW'(e);
   endtask

   task automatic set_exp(input int v, input int first, input int n, input logic ev,
                          input logic ee, input int h, input int vl);
      vecs[v].first     = first;
      vecs[v].n         = n;
      vecs[v].exp_valid = ev;
      vecs[v].exp_err   = ee;
      vecs[v].exp_h     = CW'(h);
      vecs[v].exp_v     = CW'(vl);
   endtask

   task automatic run_frame(input int idx);
      int            got_v;
      int            got_e;
      int            pend;
      int            cur;
      int            cyc;
      for (int i = 0; i < int'(LINES); i++) begin
         lf[i] = 1'b0;
         lb[i] = '0;
         le[i] = '0;
      end
      for (int k = 0; k < vecs[idx].n; k++) begin
         lf[vecs[idx].first + k] = vecs[idx].f[k];
         lb[vecs[idx].first + k] = vecs[idx].b[k];
         le[vecs[idx].first + k] = vecs[idx].e[k];
      end
      got_v = 0;
      got_e = 0;
      pend  = 0;
      cur   = 0;
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      for (cyc = 0; cyc < 20000; cyc++) begin
         if (pupil_valid) got_v++;
         if (frame_error) got_e++;
         line_ack = line_req;
         if (line_req) cur = int'(line_addr);
         if (pend == 1) begin
            scan_done  = 1'b1;
            blob_found = lf[cur];
            blob_begin = lb[cur];
            blob_end   = le[cur];
            pend       = 0;
         end else begin
            scan_done = 1'b0;
            if (pend > 1) pend--;
         end
         if (scan_start) pend = 2;
         if (!busy) break;
         @(negedge clk);
      end
      line_ack  = 1'b0;
      scan_done = 1'b0;
      check($sformatf("frame%0d_ends", idx), 32'(cyc < 20000), 32'd1);
      check($sformatf("frame%0d_valid_pulses", idx), 32'(got_v), 32'(vecs[idx].exp_valid));
      check($sformatf("frame%0d_error_pulses", idx), 32'(got_e), 32'(vecs[idx].exp_err));
      check($sformatf("frame%0d_pupil_h", idx), 32'(pupil_h), 32'(vecs[idx].exp_h));
      check($sformatf("frame%0d_pupil_v", idx), 32'(pupil_v), 32'(vecs[idx].exp_v));
      @(negedge clk);
      check($sformatf("frame%0d_quiet_after", idx), 32'({busy, pupil_valid, frame_error}), 32'd0);
   endtask

   initial begin
      int n;
      logic stray;

      // Growing then shrinking blob: widths 10,20,30,22, centre 55 on line 2
      set_exp(0, 0, 4, 1'b1, 1'b0, 55, 2);
      set_line(0, 0, 1'b1, 50, 60);
      set_line(0, 1, 1'b1, 45, 65);
      set_line(0, 2, 1'b1, 40, 70);
      set_line(0, 3, 1'b1, 44, 66);
      // Reversed edges ignored, plateau of 10 on 5..7 keeps line 5, shrink on 8
      set_exp(1, 4, 5, 1'b1, 1'b0, 35, 5);
      set_line(1, 0, 1'b1, 20, 10);
      set_line(1, 1, 1'b1, 30, 40);
      set_line(1, 2, 1'b1, 31, 41);
      set_line(1, 3, 1'b1, 32, 42);
      set_line(1, 4, 1'b1, 30, 34);
      // No blob anywhere: error after line 111, pupil outputs held
      set_exp(2, 0, 0, 1'b0, 1'b1, 35, 5);
      // Still growing on the last line: report that line
      set_exp(3, 110, 2, 1'b1, 1'b0, 15, 111);
      set_line(3, 0, 1'b1, 10, 20);
      set_line(3, 1, 1'b1, 5, 25);
      // Zero-width blob is not a blob
      set_exp(4, 0, 1, 1'b0, 1'b1, 15, 111);
      set_line(4, 0, 1'b1, 50, 50);
      // Plateau reaching the last line keeps the earlier line
      set_exp(5, 110, 2, 1'b1, 1'b0, 50, 110);
      set_line(5, 0, 1'b1, 0, 100);
      set_line(5, 1, 1'b1, 5, 105);

      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({line_req, line_addr, scan_start, pupil_h, pupil_v, pupil_valid, frame_error, busy}),
            32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) run_frame(v);

      // Handshake timing with line_ack tied high; second frame_start while busy
      line_ack = 1'b1;
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      check("hs_line_req_t1", 32'({line_req, scan_start, busy}), 32'b101);
      check("hs_line_addr_t1", 32'(line_addr), 32'd0);
      @(negedge clk);
      check("hs_scan_start_t2", 32'({line_req, scan_start}), 32'b01);
      frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      check("hs_scan_start_width", 32'(scan_start), 32'd0);
      n = 0;
      while (!frame_error && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("wait_scan_timeout_cycles", 32'(n), 32'd255);
      check("wait_scan_timeout_idle", 32'(busy), 32'd0);
      @(negedge clk);
      check("busy_frame_start_ignored", 32'({busy, frame_error, line_req}), 32'd0);
      line_ack = 1'b0;

      // line_ack never arrives: error after 255 cycles in REQ_LINE, outputs held
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      n = 1;
      while (!frame_error && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("req_line_timeout_cycles", 32'(n), 32'd256);
      check("req_line_timeout_hold", 32'({pupil_h, pupil_v, pupil_valid, line_req}),
            32'({8'd50, 8'd110, 1'b0, 1'b0}));

      // line_ack on the expiry cycle wins over the timeout
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      repeat (254) @(negedge clk);
      check("expiry_cycle_still_req", 32'(line_req), 32'd1);
      line_ack = 1'b1;
      @(negedge clk);
      line_ack = 1'b0;
      check("expiry_ack_scan_start", 32'({scan_start, frame_error}), 32'b10);
      @(negedge clk);

      // Async reset inside WAIT_SCAN, between clock edges
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            32'({line_req, line_addr, scan_start, pupil_h, pupil_v, pupil_valid, frame_error, busy}),
            32'd0);
      @(negedge clk) rst_n = 1'b1;
      scan_done  = 1'b1;
      line_ack   = 1'b1;
      blob_found = 1'b1;
      blob_begin = 8'd10;
      blob_end   = 8'd30;
      @(negedge clk);
      scan_done = 1'b0;
      line_ack  = 1'b0;
      stray     = 1'b0;
      repeat (6) begin
         stray = stray | busy | pupil_valid | frame_error | scan_start | line_req;
         @(negedge clk);
      end
      check("post_reset_ignores_handshake", 32'(stray), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
